// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control unit.
//   state_t      : instruction sequencing states
//   OP_*         : 3-bit opcode encodings
//   ALUOP_PASS   : ALU "pass operand a" select (all-ones, truncated to ALUOp width)
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  localparam logic [2:0] OP_LDR   = 3'b000;
  localparam logic [2:0] OP_STR   = 3'b001;
  localparam logic [2:0] OP_MOV   = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b101;
  localparam logic [2:0] OP_CMP   = 3'b110;
  localparam logic [2:0] OP_BR    = 3'b111;

  localparam logic [31:0] ALUOP_PASS = '1;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on data memory.
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  synchronous active-high reset
//   clear    in  restart the count (asserted the cycle before MEM is entered)
//   count_en in  advance the count (asserted in every MEM cycle)
//   expired  out count has reached MEM_TIMEOUT-1, i.e. this is the last allowed MEM cycle
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wait_cnt <= '0;
    end else if (count_en) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign expired = (wait_cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle processor control unit.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, latching the
// opcode in FETCH, and drives the datapath strobes for each state. MEM waits
// on mem_ready, giving up after MEM_TIMEOUT cycles and flagging mem_err.
// Ports:
//   Clk, Reset             clock / synchronous active-high reset
//   instr                  opcode field, sampled in FETCH
//   br_logic               branch condition, used in EXEC of BR
//   mem_ready              data memory ack, only observed in MEM
//   PCWrite, IRWrite, Branch, MemtoReg, MemWrite, MemRead, ALUSrc, RegWrite,
//   ALUOp                  datapath controls
//   mem_err                sticky memory timeout flag
//   busy                   high outside FETCH
//   retired_cnt, stall_cnt performance counters (only with MULTICYCLE_PERF_EN)
// All outputs are forced to 0 while Reset is high.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OPWIDTH     = 3,
  parameter int unsigned MCODEBITS   = 3,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 br_logic,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 mem_err,
  output logic                 busy
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0]          retired_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  state_t               state, state_next;
  logic [MCODEBITS-1:0] opcode_q;
  logic                 mem_err_q;
  logic                 expired;
  logic                 mem_exit;
  logic                 op_mem, op_alu;
  logic                 is_ldr, is_str, is_cmp;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (Clk),
    .reset   (Reset),
    .clear   (state == EXEC),
    .count_en(state == MEM),
    .expired (expired)
  );

  // Opcode classes; encodings outside the table (wider fields) decode as NOP.
  always_comb begin
    op_mem = 1'b0;
    op_alu = 1'b0;
    case (opcode_q)
      MCODEBITS'(OP_LDR), MCODEBITS'(OP_STR): op_mem = 1'b1;
      MCODEBITS'(OP_MOV), MCODEBITS'(OP_XOR), MCODEBITS'(OP_AND),
      MCODEBITS'(OP_SHIFT), MCODEBITS'(OP_CMP): op_alu = 1'b1;
      default: ;
    endcase
  end

  assign is_ldr   = (opcode_q == MCODEBITS'(OP_LDR));
  assign is_str   = (opcode_q == MCODEBITS'(OP_STR));
  assign is_cmp   = (opcode_q == MCODEBITS'(OP_CMP));
  // A ready in the timeout cycle counts as success.
  assign mem_exit = mem_ready || expired;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= FETCH;
      opcode_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == FETCH) begin
        opcode_q <= instr;
      end
      if (state == MEM && expired && !mem_ready) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: state_next = EXEC;
      EXEC: begin
        if (op_mem)      state_next = MEM;
        else if (op_alu) state_next = WB;
        else             state_next = FETCH;
      end
      MEM: begin
        if (mem_exit) state_next = is_ldr ? WB : FETCH;
      end
      WB:      state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    Branch   = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    ALUOp    = '0;
    mem_err  = 1'b0;
    busy     = 1'b0;
    if (!Reset) begin
      ALUOp   = OPWIDTH'(ALUOP_PASS);
      mem_err = mem_err_q;
      busy    = (state != FETCH);
      case (state)
        FETCH: IRWrite = 1'b1;
        EXEC: begin
          ALUOp = OPWIDTH'(opcode_q);
          if (op_mem) begin
            ALUSrc = 1'b1;
          end else if (!op_alu) begin
            // BR, and NOP for unused encodings (Branch only for BR)
            PCWrite = 1'b1;
            Branch  = (opcode_q == MCODEBITS'(OP_BR)) && br_logic;
          end
        end
        MEM: begin
          ALUOp    = OPWIDTH'(opcode_q);
          ALUSrc   = 1'b1;
          MemRead  = is_ldr;
          MemWrite = is_str;
          PCWrite  = is_str && mem_exit;
        end
        WB: begin
          PCWrite  = 1'b1;
          RegWrite = !is_cmp;
          MemtoReg = is_ldr;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (PCWrite) retired_q <= retired_q + 32'd1;
      if (state == MEM && !mem_ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign retired_cnt = Reset ? '0 : retired_q;
  assign stall_cnt   = Reset ? '0 : stall_q;
`endif

endmodule
